// File: rtl/decode_queue.sv
// decode_queue: RISC-V instruction decoder in front of a small FIFO of decoded records.
// Instructions are decoded combinationally at push time, and the full record is
// stored per slot. The head record is driven out, and all outputs read as zero
// while the queue is empty.
//
// Handshake: both sides use strict valid/ready. A push happens on a rising edge
// with iValid=1, oReady=1 and iFlush=0. A pop happens on a rising edge with
// oValid=1 and iReady=1. oReady depends only on the stored count, so a full
// queue refuses a push even when a pop happens in the same cycle. Neither
// oReady nor oValid depends combinationally on the opposite side's strobe.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iFlush,
  input  logic             iValid,
  output logic             oReady,
  input  logic [31:0]      iInstr,
  input  logic [XLEN-1:0]  iPC,
  output logic             oValid,
  input  logic             iReady,
  output logic [2:0]       oInstructionType,
  output logic [3:0]       oInstructionSubType,
  output logic [4:0]       oRd,
  output logic [4:0]       oRs1,
  output logic [4:0]       oRs2,
  output logic [XLEN-1:0]  oImm,
  output logic [XLEN-1:0]  oPC,
  output logic             oNop,
  output logic [CNT_W-1:0] oIllegalCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [2:0] T_REG    = 3'd0;
  localparam logic [2:0] T_IMM    = 3'd1;
  localparam logic [2:0] T_LOAD   = 3'd2;
  localparam logic [2:0] T_UPPER  = 3'd3;
  localparam logic [2:0] T_STORE  = 3'd4;
  localparam logic [2:0] T_JUMP   = 3'd5;
  localparam logic [2:0] T_BRANCH = 3'd6;
  localparam logic [2:0] T_INV    = 3'd7;

  typedef struct packed {
    logic [2:0]      itype;
    logic [3:0]      sub;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            nop;
  } entry_t;

  // Decode signals
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            dec_legal;
  logic [2:0]      dec_type;
  logic [3:0]      dec_sub;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec_entry;

  // Queue state
  entry_t           slot_q [DEPTH];
  logic [PTR_W-1:0] rdptr_q, rdptr_d;
  logic [PTR_W-1:0] wrptr_q, wrptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] illegal_q, illegal_d;
  logic             push, pop;
  entry_t           head;

  // Combinational decode of the incoming word into a full record.
  // Register fields are passed through as raw bit fields for every type.
  always_comb begin
    opcode = iInstr[6:0];
    f3     = iInstr[14:12];
    f7     = iInstr[31:25];

    imm_i = {XLEN{iInstr[31]}};
    imm_i[11:0] = iInstr[31:20];
    imm_s = {XLEN{iInstr[31]}};
    imm_s[11:0] = {iInstr[31:25], iInstr[11:7]};
    imm_b = {XLEN{iInstr[31]}};
    imm_b[12:0] = {iInstr[31], iInstr[7], iInstr[30:25], iInstr[11:8], 1'b0};
    imm_u = {XLEN{iInstr[31]}};
    imm_u[31:0] = {iInstr[31:12], 12'b0};
    imm_j = {XLEN{iInstr[31]}};
    imm_j[20:0] = {iInstr[31], iInstr[19:12], iInstr[20], iInstr[30:21], 1'b0};

    dec_legal = 1'b1;
    dec_type  = T_INV;
    dec_sub   = 4'hF;
    dec_imm   = '0;

    case (opcode)
      7'd51: begin
        dec_type  = T_REG;
        dec_sub   = {iInstr[30], f3};
        dec_legal = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      7'd19: begin
        dec_type = T_IMM;
        dec_sub  = {(f3 == 3'b101) & iInstr[30], f3};
        dec_imm  = imm_i;
        // Shift-immediates reuse the funct7 field; only logical/arith forms exist.
        if (f3 == 3'b001) begin
          dec_legal = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end
      end
      7'd3: begin
        dec_type  = T_LOAD;
        dec_sub   = {1'b0, f3};
        dec_imm   = imm_i;
        dec_legal = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
      end
      7'd55: begin
        dec_type = T_UPPER;
        dec_sub  = 4'd0;
        dec_imm  = imm_u;
      end
      7'd23: begin
        dec_type = T_UPPER;
        dec_sub  = 4'd1;
        dec_imm  = imm_u;
      end
      7'd35: begin
        dec_type  = T_STORE;
        dec_sub   = {1'b0, f3};
        dec_imm   = imm_s;
        dec_legal = (f3 <= 3'b010);
      end
      7'd111: begin
        dec_type = T_JUMP;
        dec_sub  = 4'd0;
        dec_imm  = imm_j;
      end
      7'd103: begin
        dec_type  = T_JUMP;
        dec_sub   = 4'd1;
        dec_imm   = imm_i;
        dec_legal = (f3 == 3'b000);
      end
      7'd99: begin
        dec_type  = T_BRANCH;
        dec_sub   = {1'b0, f3};
        dec_imm   = imm_b;
        dec_legal = !((f3 == 3'b010) || (f3 == 3'b011));
      end
      default: dec_legal = 1'b0;
    endcase

    if (!dec_legal) begin
      dec_type = T_INV;
      dec_sub  = 4'hF;
      dec_imm  = '0;
    end

    dec_entry.itype = dec_type;
    dec_entry.sub   = dec_sub;
    dec_entry.rd    = iInstr[11:7];
    dec_entry.rs1   = iInstr[19:15];
    dec_entry.rs2   = iInstr[24:20];
    dec_entry.imm   = dec_imm;
    dec_entry.pc    = iPC;
    dec_entry.nop   = (dec_type == T_IMM) && (dec_sub == 4'd0) &&
                      (iInstr[11:7] == 5'd0) && (iInstr[19:15] == 5'd0) &&
                      (dec_imm == '0);
  end

  assign oReady = (count_q != FULL_CNT);
  assign oValid = (count_q != '0);
  assign push   = iValid && oReady && !iFlush;
  assign pop    = oValid && iReady;

  // Next-state for pointers, occupancy and the saturating illegal counter.
  always_comb begin
    rdptr_d   = rdptr_q;
    wrptr_d   = wrptr_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    if (iFlush) begin
      rdptr_d = '0;
      wrptr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrptr_d = wrptr_q + 1'b1;
      if (pop)  rdptr_d = rdptr_q + 1'b1;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (push && (dec_entry.itype == T_INV) && (illegal_q != '1)) begin
        illegal_d = illegal_q + 1'b1;
      end
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rdptr_q   <= '0;
      wrptr_q   <= '0;
      count_q   <= '0;
      illegal_q <= '0;
    end else begin
      rdptr_q   <= rdptr_d;
      wrptr_q   <= wrptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Slot storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge iClk) begin
    if (push) slot_q[wrptr_q] <= dec_entry;
  end

  assign head          = slot_q[rdptr_q];
  assign oIllegalCount = illegal_q;

  // Head record drives the outputs only while an entry is present.
  always_comb begin
    oInstructionType    = '0;
    oInstructionSubType = '0;
    oRd                 = '0;
    oRs1                = '0;
    oRs2                = '0;
    oImm                = '0;
    oPC                 = '0;
    oNop                = 1'b0;
    if (oValid) begin
      oInstructionType    = head.itype;
      oInstructionSubType = head.sub;
      oRd                 = head.rd;
      oRs1                = head.rs1;
      oRs2                = head.rs2;
      oImm                = head.imm;
      oPC                 = head.pc;
      oNop                = head.nop;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: self-checking bench for decode_queue (XLEN=64, DEPTH=4,
// 3-bit illegal counter so saturation is reachable).
module tb_decode_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int RW    = 151;

  // Clock/reset and DUT signals
  logic             iClk = 1'b0;
  logic             iRstN, iFlush, iValid, iReady;
  logic [31:0]      iInstr;
  logic [XLEN-1:0]  iPC;
  logic             oReady, oValid, oNop;
  logic [2:0]       oInstructionType;
  logic [3:0]       oInstructionSubType;
  logic [4:0]       oRd, oRs1, oRs2;
  logic [XLEN-1:0]  oImm, oPC;
  logic [CNT_W-1:0] oIllegalCount;

  int errors = 0;
  int checks = 0;

  // Scoreboard
  logic [RW-1:0]    exp_q[$];
  logic [RW-1:0]    drv_exp;
  logic [CNT_W-1:0] exp_ill;
  logic [RW-1:0]    head_rec;

  always #5 iClk = ~iClk;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRstN(iRstN), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
    .iInstr(iInstr), .iPC(iPC), .oValid(oValid), .iReady(iReady),
    .oInstructionType(oInstructionType), .oInstructionSubType(oInstructionSubType),
    .oRd(oRd), .oRs1(oRs1), .oRs2(oRs2), .oImm(oImm), .oPC(oPC), .oNop(oNop),
    .oIllegalCount(oIllegalCount)
  );

  assign head_rec = {oInstructionType, oInstructionSubType, oRd, oRs1, oRs2, oImm, oPC, oNop};

  function automatic logic [RW-1:0] mk(logic [2:0] t, logic [3:0] s, logic [4:0] rd,
                                        logic [4:0] rs1, logic [4:0] rs2,
                                        logic [63:0] imm, logic [63:0] pc, logic nop);
    return {t, s, rd, rs1, rs2, imm, pc, nop};
  endfunction

  // Driver tasks
  task automatic drive_push(input logic [31:0] w, input logic [63:0] pc, input logic [RW-1:0] e);
    iValid  = 1'b1;
    iInstr  = w;
    iPC     = pc;
    drv_exp = e;
  endtask

  task automatic drive_idle();
    iValid = 1'b0;
    iInstr = '0;
    iPC    = '0;
  endtask

  // One clock: update the reference queue from the handshake as the model sees it.
  task automatic tick();
    logic push_ok, pop_ok, flush_now;
    push_ok   = iValid && !iFlush && (exp_q.size() != DEPTH);
    pop_ok    = iReady && (exp_q.size() != 0);
    flush_now = iFlush;
    @(posedge iClk);
    if (flush_now) begin
      exp_q.delete();
    end else begin
      if (pop_ok) void'(exp_q.pop_front());
      if (push_ok) begin
        exp_q.push_back(drv_exp);
        if (drv_exp[RW-1 -: 3] == 3'd7 && exp_ill != '1) exp_ill = exp_ill + 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    iRstN = 1'b1; iFlush = 1'b0; iReady = 1'b0; drv_exp = '0;
    drive_idle();
    #2 iRstN = 1'b0;
    #10;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", oReady); end
    checks++; if (oIllegalCount !== '0) begin errors++; $display("FAIL reset_illegal: got %0d expected 0", oIllegalCount); end
    checks++; if (head_rec !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", head_rec); end
    @(posedge iClk); #1;
    iRstN = 1'b1;
    exp_q.delete();
    exp_ill = '0;
  endtask

  task automatic test_nop();
    drive_push(32'h00000013, 64'h100, mk(3'd1, 4'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'h100, 1'b1));
    #1;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL nop_no_comb_path: got %b expected 0", oValid); end
    tick();
    drive_idle();
    checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL nop_latency: got %b expected 1", oValid); end
    checks++; if (oNop !== 1'b1) begin errors++; $display("FAIL nop_flag: got %b expected 1", oNop); end
    checks++; if (head_rec !== exp_q[0]) begin errors++; $display("FAIL nop_record: got %h expected %h", head_rec, exp_q[0]); end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checks++; if (oValid !== 1'b0 || head_rec !== '0) begin
      errors++; $display("FAIL empty_outputs_zero: got valid=%b rec=%h expected 0", oValid, head_rec);
    end
  endtask

  task automatic test_decode_table();
    logic [31:0]   words [10];
    logic [RW-1:0] exps  [10];
    logic [63:0]   pc;
    words[0] = 32'h40B50533; words[1] = 32'hFFF00093; words[2] = 32'h40525193;
    words[3] = 32'h80000117; words[4] = 32'h00812283; words[5] = 32'hFE512E23;
    words[6] = 32'hFE208CE3; words[7] = 32'h001000EF; words[8] = 32'h00008067;
    words[9] = 32'h12345537;
    for (int i = 0; i < 10; i++) begin
      pc = 64'h1000 + 64'(4 * i);
      case (i)
        0: exps[i] = mk(3'd0, 4'b1000, 5'd10, 5'd10, 5'd11, 64'd0, pc, 1'b0);
        1: exps[i] = mk(3'd1, 4'd0, 5'd1, 5'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, pc, 1'b0);
        2: exps[i] = mk(3'd1, 4'hD, 5'd3, 5'd4, 5'd5, 64'h405, pc, 1'b0);
        3: exps[i] = mk(3'd3, 4'd1, 5'd2, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, pc, 1'b0);
        4: exps[i] = mk(3'd2, 4'd2, 5'd5, 5'd2, 5'd8, 64'h8, pc, 1'b0);
        5: exps[i] = mk(3'd4, 4'd2, 5'd28, 5'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFC, pc, 1'b0);
        6: exps[i] = mk(3'd6, 4'd0, 5'd25, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8, pc, 1'b0);
        7: exps[i] = mk(3'd5, 4'd0, 5'd1, 5'd0, 5'd1, 64'h800, pc, 1'b0);
        8: exps[i] = mk(3'd5, 4'd1, 5'd0, 5'd1, 5'd0, 64'd0, pc, 1'b0);
        default: exps[i] = mk(3'd3, 4'd0, 5'd10, 5'd8, 5'd3, 64'h1234_5000, pc, 1'b0);
      endcase
      drive_push(words[i], pc, exps[i]);
      tick();
      drive_idle();
      checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
        errors++; $display("FAIL decode_%0d: got valid=%b rec=%h expected %h", i, oValid, head_rec, exp_q[0]);
      end
      iReady = 1'b1;
      tick();
      iReady = 1'b0;
    end
    checks++; if (oIllegalCount !== exp_ill) begin errors++; $display("FAIL legal_no_count: got %0d expected %0d", oIllegalCount, exp_ill); end
  endtask

  task automatic test_full();
    logic [31:0] w;
    iReady = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      w = (32'(n) << 20) | (32'(n) << 7) | 32'h13;
      drive_push(w, 64'h2000 + 64'(n), mk(3'd1, 4'd0, 5'(n), 5'd0, 5'(n), 64'(n), 64'h2000 + 64'(n), 1'b0));
      checks++; if (oReady !== (exp_q.size() != DEPTH)) begin
        errors++; $display("FAIL full_ready_%0d: got %b expected %b", n, oReady, exp_q.size() != DEPTH);
      end
      if (n == 6) begin
        // Pop and push together while full: push must still be refused.
        iReady = 1'b1;
        checks++; if (head_rec !== exp_q[0]) begin errors++; $display("FAIL full_head: got %h expected %h", head_rec, exp_q[0]); end
      end
      tick();
    end
    drive_idle();
    checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL full_pop_frees: got %b expected 1", oReady); end
    for (int k = 0; k < 6 && exp_q.size() != 0; k++) begin
      checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
        errors++; $display("FAIL full_drain_%0d: got valid=%b rec=%h expected %h", k, oValid, head_rec, exp_q[0]);
      end
      tick();
    end
    iReady = 1'b0;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", oValid); end
  endtask

  task automatic test_illegal();
    logic [31:0]   words [9];
    logic [RW-1:0] exps  [9];
    words[0] = 32'hFFFFFFFF; exps[0] = mk(3'd7, 4'hF, 5'd31, 5'd31, 5'd31, 64'd0, 64'h3000, 1'b0);
    words[1] = 32'h0000302F; exps[1] = mk(3'd7, 4'hF, 5'd0, 5'd0, 5'd0, 64'd0, 64'h3004, 1'b0);
    iReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_push(words[i], 64'h3000 + 64'(4 * i), exps[i]);
      tick();
    end
    drive_idle();
    checks++; if (oIllegalCount !== exp_ill) begin errors++; $display("FAIL illegal_count_two: got %0d expected %0d", oIllegalCount, exp_ill); end
    iReady = 1'b1;
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
        errors++; $display("FAIL illegal_rec_%0d: got %h expected %h", k, head_rec, exp_q[0]);
      end
      tick();
    end
    words[2] = 32'h00009067; exps[2] = mk(3'd7, 4'hF, 5'd0, 5'd1, 5'd0, 64'd0, 64'h3008, 1'b0);
    words[3] = 32'h40001033; exps[3] = mk(3'd7, 4'hF, 5'd0, 5'd0, 5'd0, 64'd0, 64'h300C, 1'b0);
    words[4] = 32'h0000B083; exps[4] = mk(3'd7, 4'hF, 5'd1, 5'd1, 5'd0, 64'd0, 64'h3010, 1'b0);
    words[5] = 32'h02000033; exps[5] = mk(3'd7, 4'hF, 5'd0, 5'd0, 5'd0, 64'd0, 64'h3014, 1'b0);
    words[6] = 32'h00002063; exps[6] = mk(3'd7, 4'hF, 5'd0, 5'd0, 5'd0, 64'd0, 64'h3018, 1'b0);
    words[7] = 32'h00003023; exps[7] = mk(3'd7, 4'hF, 5'd0, 5'd0, 5'd0, 64'd0, 64'h301C, 1'b0);
    words[8] = 32'h40001013; exps[8] = mk(3'd7, 4'hF, 5'd0, 5'd0, 5'd0, 64'd0, 64'h3020, 1'b0);
    for (int i = 2; i < 9; i++) begin
      drive_push(words[i], 64'h3000 + 64'(4 * i), exps[i]);
      if (exp_q.size() != 0) begin
        checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
          errors++; $display("FAIL illegal_stream_%0d: got %h expected %h", i, head_rec, exp_q[0]);
        end
      end
      tick();
    end
    drive_idle();
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
        errors++; $display("FAIL illegal_tail_%0d: got %h expected %h", k, head_rec, exp_q[0]);
      end
      tick();
    end
    iReady = 1'b0;
    checks++; if (oIllegalCount !== exp_ill) begin errors++; $display("FAIL illegal_saturate: got %0d expected %0d", oIllegalCount, exp_ill); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [63:0] pc;
    iReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imm = 12'($urandom_range(0, 4095));
      rd  = 5'($urandom_range(1, 31));
      pc  = 64'h4000 + 64'(4 * i);
      drive_push({imm, 5'd0, 3'b000, rd, 7'h13}, pc,
                 mk(3'd1, 4'd0, rd, 5'd0, imm[4:0], {{52{imm[11]}}, imm}, pc, 1'b0));
      checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, oReady); end
      if (i > 0) begin
        checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
          errors++; $display("FAIL b2b_head_%0d: got valid=%b rec=%h expected %h", i, oValid, head_rec, exp_q[0]);
        end
      end
      tick();
    end
    drive_idle();
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
        errors++; $display("FAIL b2b_tail_%0d: got %h expected %h", k, head_rec, exp_q[0]);
      end
      tick();
    end
    iReady = 1'b0;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", oValid); end
  endtask

  task automatic test_flush();
    logic [31:0] w;
    iReady = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      w = (32'(n) << 20) | (32'(n) << 7) | 32'h13;
      drive_push(w, 64'h5000 + 64'(n), mk(3'd1, 4'd0, 5'(n), 5'd0, 5'(n), 64'(n), 64'h5000 + 64'(n), 1'b0));
      tick();
    end
    drive_push(32'hFFFFFFFF, 64'h5100, mk(3'd7, 4'hF, 5'd31, 5'd31, 5'd31, 64'd0, 64'h5100, 1'b0));
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    drive_idle();
    checks++; if (oValid !== 1'b0 || oReady !== 1'b1) begin
      errors++; $display("FAIL flush_empty: got valid=%b ready=%b expected 0/1", oValid, oReady);
    end
    checks++; if (oIllegalCount !== exp_ill) begin errors++; $display("FAIL flush_illegal: got %0d expected %0d", oIllegalCount, exp_ill); end
    drive_push(32'h00700393, 64'h5200, mk(3'd1, 4'd0, 5'd7, 5'd0, 5'd7, 64'd7, 64'h5200, 1'b0));
    tick();
    drive_idle();
    checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
      errors++; $display("FAIL flush_after: got valid=%b rec=%h expected %h", oValid, head_rec, exp_q[0]);
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
  endtask

  task automatic test_async_reset();
    iReady = 1'b0;
    drive_push(32'h0000302F, 64'h6000, mk(3'd7, 4'hF, 5'd0, 5'd0, 5'd0, 64'd0, 64'h6000, 1'b0));
    tick();
    drive_push(32'h00100093, 64'h6004, mk(3'd1, 4'd0, 5'd1, 5'd0, 5'd1, 64'd1, 64'h6004, 1'b0));
    tick();
    drive_idle();
    #2 iRstN = 1'b0;
    exp_q.delete();
    exp_ill = '0;
    #1;
    checks++; if (oValid !== 1'b0 || oReady !== 1'b1) begin
      errors++; $display("FAIL async_reset_flags: got valid=%b ready=%b expected 0/1", oValid, oReady);
    end
    checks++; if (oIllegalCount !== '0) begin errors++; $display("FAIL async_reset_illegal: got %0d expected 0", oIllegalCount); end
    @(posedge iClk); #1;
    iRstN = 1'b1;
    drive_push(32'h00200113, 64'h6100, mk(3'd1, 4'd0, 5'd2, 5'd0, 5'd2, 64'd2, 64'h6100, 1'b0));
    tick();
    drive_idle();
    checks++; if (oValid !== 1'b1 || head_rec !== exp_q[0]) begin
      errors++; $display("FAIL reset_first_push: got valid=%b rec=%h expected %h", oValid, head_rec, exp_q[0]);
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nop();
    test_decode_table();
    test_full();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
